dot_frame_buf: RTL and testbench

Double-buffered 8x8 frame store for the dot-matrix display. The CPU side writes row patterns into a back bank. The scan side presents the row index from the display row-scan counter and receives registered column data plus a one-hot row select from the front bank. A CPU swap request is held pending and takes effect only at the frame boundary (scan row 7 -> 0), so a displayed frame is never torn.

---
 rtl/dot_pkg.sv | 11 +
 rtl/dot_bank.sv | 36 +++
 rtl/dot_frame_buf.sv | 114 +++++++++++
 tb/tb_dot_frame_buf.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared constants for the dot-matrix display path.
// The frame buffer and the row-scan counter both use these values.
package dot_pkg;
   localparam int ROWS  = 8;
   localparam int COLS  = 8;
   localparam int ROW_W = 3;

   typedef logic [ROW_W-1:0] row_t;

   localparam row_t LAST_ROW = row_t'(ROWS - 1);
endpackage

// File: rtl/dot_bank.sv
// One 8 x COLS frame bank.
// It has one synchronous row-write port and one combinational row-read port.
// A whole-bank load port is used to copy the other bank on a swap.
// The whole contents are also exported so the other bank can load them.
module dot_bank
   import dot_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_we,
   input  row_t                       i_waddr,
   input  logic [COLS-1:0]            i_wdata,
   input  logic                       i_ld,
   input  logic [ROWS-1:0][COLS-1:0]  i_ld_data,
   input  row_t                       i_raddr,
   output logic [COLS-1:0]            o_rdata,
   output logic [ROWS-1:0][COLS-1:0]  o_mem
);

   logic [ROWS-1:0][COLS-1:0] r_mem;

   // Storage: a whole-bank load takes priority over a single-row write.
   // The front-end never issues both in the same cycle anyway.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_mem <= '0;
      else if (i_ld)
         r_mem <= i_ld_data;
      else if (i_we)
         r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
   assign o_mem   = r_mem;

endmodule

// File: rtl/dot_frame_buf.sv
// Double-buffered 8x8 frame store for the dot-matrix display.
// The CPU writes the back bank, and the scan side reads the front bank.
// A swap request waits until the frame boundary (scan row 7 -> 0),
// so a displayed frame is never torn.
// Optional: DOT_FRAME_COPY_EN makes the swap also copy the new front bank
// into the new back bank, so both banks are equal after a swap.
module dot_frame_buf
   import dot_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [ROW_W-1:0]    wr_row,
   input  logic [COLS-1:0]     wr_data,
   output logic                wr_ready,
   input  logic                swap_req,
   output logic                swap_ack,
   input  logic [ROW_W-1:0]    scan_row,
   output logic [COLS-1:0]     col_out,
   output logic [ROWS-1:0]     row_sel
);

   logic                       r_front;
   logic                       r_pending;
   row_t                       r_prev_row;

   logic                       w_boundary;
   logic                       w_swap;
   logic                       w_front_next;
   logic                       w_wr_fire;
   logic                       w_we0, w_we1;
   logic                       w_ld0, w_ld1;
   logic [COLS-1:0]            w_rd0, w_rd1;
   logic [ROWS-1:0][COLS-1:0]  w_mem0, w_mem1;

   assign w_boundary   = (r_prev_row == LAST_ROW) && (scan_row == '0);
   assign w_swap       = w_boundary && r_pending;
   // The new frame's row 0 must already come from the new front bank.
   assign w_front_next = r_front ^ w_swap;

   // Writes are blocked while a swap is pending. For that reason a write
   // and a swap never happen in the same cycle.
   assign wr_ready  = ~r_pending;
   assign w_wr_fire = wr_en && ~r_pending;
   assign w_we0     = w_wr_fire &&  r_front;
   assign w_we1     = w_wr_fire && ~r_front;

`ifdef DOT_FRAME_COPY_EN
   // The old front bank becomes the new back bank.
   // It takes a copy of the old back bank, which is the new front.
   assign w_ld0 = w_swap && ~r_front;
   assign w_ld1 = w_swap &&  r_front;
`else
   assign w_ld0 = 1'b0;
   assign w_ld1 = 1'b0;
`endif

   dot_bank u_bank0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (w_we0),
      .i_waddr   (wr_row),
      .i_wdata   (wr_data),
      .i_ld      (w_ld0),
      .i_ld_data (w_mem1),
      .i_raddr   (scan_row),
      .o_rdata   (w_rd0),
      .o_mem     (w_mem0)
   );

   dot_bank u_bank1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (w_we1),
      .i_waddr   (wr_row),
      .i_wdata   (wr_data),
      .i_ld      (w_ld1),
      .i_ld_data (w_mem0),
      .i_raddr   (scan_row),
      .o_rdata   (w_rd1),
      .o_mem     (w_mem1)
   );

   // Swap control. A request while one is already pending is dropped.
   // A request in a boundary cycle waits for the next boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_front    <= 1'b0;
         r_pending  <= 1'b0;
         r_prev_row <= '0;
         swap_ack   <= 1'b0;
      end else begin
         r_prev_row <= scan_row;
         r_front    <= w_front_next;
         swap_ack   <= w_swap;
         if (w_swap)
            r_pending <= 1'b0;
         else if (swap_req)
            r_pending <= 1'b1;
      end
   end

   // Registered scan outputs, one cycle behind scan_row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_out <= '0;
         row_sel <= '0;
      end else begin
         col_out <= w_front_next ? w_rd1 : w_rd0;
         row_sel <= ROWS'(1) << scan_row;
      end
   end

endmodule

// File: tb/tb_dot_frame_buf.sv
// Self-checking bench for dot_frame_buf.
// It uses directed steps plus randomized traffic, checked against a frame-level model.
module tb_dot_frame_buf;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [2:0] wr_row;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       swap_req;
   logic       swap_ack;
   logic [2:0] scan_row;
   logic [7:0] col_out;
   logic [7:0] row_sel;

   int n_pass = 0;
   int n_tot  = 0;
   int n_acks = 0;

   // Reference model: two frames, which one is shown, whether a swap is owed,
   // and the last row seen on the scan input.
   logic [7:0] m_bank [2][8];
   bit         m_front;
   bit         m_pending;
   logic [2:0] m_prev;

   dot_frame_buf dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_row   (wr_row),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .swap_req (swap_req),
      .swap_ack (swap_ack),
      .scan_row (scan_row),
      .col_out  (col_out),
      .row_sel  (row_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 8; r++)
            m_bank[b][r] = 8'h00;
      m_front   = 1'b0;
      m_pending = 1'b0;
      m_prev    = 3'd0;
   endtask

   // Predict one clock from the current inputs, let it happen, then compare.
   task automatic tick();
      bit         bnd, sw, nf;
      logic [7:0] ecol, ers;
      bnd  = (m_prev == 3'd7) && (scan_row == 3'd0);
      sw   = bnd && m_pending;
      nf   = m_front ^ sw;
      ecol = m_bank[nf][scan_row];
      ers  = 8'd1 << scan_row;
      if (wr_en && !m_pending)
         m_bank[!m_front][wr_row] = wr_data;
`ifdef DOT_FRAME_COPY_EN
      if (sw)
         for (int r = 0; r < 8; r++)
            m_bank[m_front][r] = m_bank[nf][r];
`endif
      if (sw)
         m_pending = 1'b0;
      else if (swap_req)
         m_pending = 1'b1;
      m_prev  = scan_row;
      m_front = nf;
      @(posedge clk);
      #1;
      if (swap_ack === 1'b1) n_acks++;
      chk("col_out",  {24'd0, col_out},  {24'd0, ecol});
      chk("row_sel",  {24'd0, row_sel},  {24'd0, ers});
      chk("swap_ack", {31'd0, swap_ack}, {31'd0, sw});
      chk("wr_ready", {31'd0, wr_ready}, {31'd0, !m_pending});
   endtask

   task automatic idle_in();
      wr_en = 1'b0; wr_row = 3'd0; wr_data = 8'h00; swap_req = 1'b0;
   endtask

   task automatic frame();
      for (int r = 0; r < 8; r++) begin
         scan_row = 3'(r);
         tick();
      end
   endtask

   task automatic chk_zero_outs(input string tag);
      chk({tag, "_col"},   {24'd0, col_out},  32'd0);
      chk({tag, "_row"},   {24'd0, row_sel},  32'd0);
      chk({tag, "_ack"},   {31'd0, swap_ack}, 32'd0);
      chk({tag, "_ready"}, {31'd0, wr_ready}, 32'd1);
   endtask

   initial begin
      int acks0;
      rst_n = 1'b0; scan_row = 3'd0;
      idle_in();
      model_reset();
      #12;
      chk_zero_outs("reset");
      rst_n = 1'b1;

      // Blank frame after reset: row_sel walks 0x01..0x80 and col_out stays 0.
      frame();

      // Fill the back bank with 0x11*k, request a swap, then show it.
      scan_row = 3'd7;
      for (int k = 0; k < 8; k++) begin
         wr_en = 1'b1; wr_row = 3'(k); wr_data = 8'(8'h11 * k);
         tick();
      end
      idle_in();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      acks0 = n_acks;
      frame();
      frame();
      chk("single_ack_fill", n_acks - acks0, 1);

      // Request at row 3. A write of 0xFF to row 2 is blocked while the swap is pending.
      for (int r = 0; r < 8; r++) begin
         scan_row = 3'(r);
         swap_req = (r == 3);
         if (r == 4) begin wr_en = 1'b1; wr_row = 3'd2; wr_data = 8'hFF; end
         else wr_en = 1'b0;
         tick();
      end
      idle_in();
      frame();
      frame();

      // Request in the boundary cycle itself, then more requests while it is pending.
      acks0 = n_acks;
      for (int r = 0; r < 8; r++) begin
         scan_row = 3'(r);
         swap_req = (r <= 3) || (r == 6);
         tick();
      end
      swap_req = 1'b0;
      chk("no_ack_same_boundary", n_acks - acks0, 0);
      frame();
      frame();
      chk("single_ack_repeat", n_acks - acks0, 1);

      // Update only row 5 = 0xA5, then swap.
      scan_row = 3'd7;
      wr_en = 1'b1; wr_row = 3'd5; wr_data = 8'hA5;
      tick();
      idle_in();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      frame();
      frame();

      // Random traffic with occasional scan stalls.
      for (int i = 0; i < 400; i++) begin
         wr_en    = ($urandom_range(0, 1) == 1);
         wr_row   = 3'($urandom_range(0, 7));
         wr_data  = 8'($urandom);
         swap_req = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) != 0) scan_row = scan_row + 3'd1;
         tick();
      end
      idle_in();

      // Make a swap pending, then reset asynchronously while scan_row is 4.
      scan_row = 3'd7;
      tick();
      for (int r = 0; r < 5; r++) begin
         scan_row = 3'(r);
         swap_req = (r == 2);
         tick();
      end
      swap_req = 1'b0;
      chk("pending_before_rst", {31'd0, wr_ready}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk_zero_outs("midrst");
      model_reset();
      #3 rst_n = 1'b1;
      acks0 = n_acks;
      for (int r = 5; r < 8; r++) begin
         scan_row = 3'(r);
         tick();
      end
      frame();
      frame();
      chk("no_ack_after_rst", n_acks - acks0, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
